exponent_core: RTL and testbench
================================

// Module: exponent_core
// PURPOSE
//  Iterative integer power unit: result = base^exp, truncated to 32 bits, by square-and-multiply (one exponent bit per clock).
//  Sits directly downstream of exponent_axi4_lite_slave. The slave writes operand registers, pulses start_i, polls busy_o,
//  and captures result_o/overflow_o on done_o. It runs in the AXI clock domain, with no CDC.
// PARAMETERS
//  DATA_W  32  width of base_i, result_o and internal accumulator/base registers
//  EXP_W   32  width of exp_i and the exponent shift register
// PORTS
//  S_AXI_ACLK     in   1       clock; all state updates on rising edge
//  S_AXI_ARESETN  in   1       asynchronous active-low reset
//  start_i        in   1       request; sampled only in IDLE
//  base_i         in   DATA_W  base operand, latched on accepted start
//  exp_i          in   EXP_W   exponent operand, latched on accepted start
//  busy_o         out  1       high in RUN and DONE states
//  done_o         out  1       one-cycle pulse: result_o/overflow_o valid
//  result_o       out  DATA_W  base^exp mod 2^DATA_W; held until next accepted start
//  overflow_o     out  1       sticky: true result exceeded DATA_W bits
// BEHAVIOUR
//  Reset (async, ARESETN=0): state=IDLE; busy_o=0, done_o=0, result_o=0, overflow_o=0.
//    All internal registers are cleared. A reset mid-RUN aborts the operation with no done_o pulse.
//  Internal regs: acc[DATA_W], b[DATA_W], e[EXP_W], b_ovf (squared base no longer exact).
//  FSM:
//   IDLE: if start_i, latch b<=base_i, e<=exp_i, acc<=1, b_ovf<=0, overflow_o<=0, then go to RUN.
//     result_o is NOT cleared at start.
//   RUN: if e==0, go to DONE with no update.
//     Otherwise, in one cycle:
//      - if e[0]: acc <= low(acc*b); set overflow_o if high half of 2*DATA_W product !=0 or b_ovf=1
//      - b <= low(b*b); b_ovf <= b_ovf | (high half of b*b !=0)
//      - e <= e>>1; stay in RUN
//   DONE: result_o<=acc, done_o=1 for exactly this cycle, then go to IDLE.
//  Latency: done_o is high in cycle bitlen(exp)+2 after the start-sampling edge. bitlen(0)=0.
//    Examples: exp=0 gives 2 cycles; exp=5 gives 5 cycles; worst case exp=2^32-1 gives 34 cycles.
//  start_i is ignored in RUN and DONE (no queueing). Back-to-back: the earliest next accept is the cycle after DONE.
//  Operands may change after the accept; only latched copies are used.
//  Arithmetic: full DATA_W x DATA_W -> 2*DATA_W unsigned multiply, low half kept; one multiplier for acc and one for b,
//    both in the same cycle. A trailing squaring overflow (b_ovf) that is never multiplied into acc does NOT set overflow_o.
//  Edge cases: 0^0=1; 0^n=0 for n>0; 1^n=1; x^1=x. None of these sets overflow_o.
// TESTING
//  1. base=3, exp=5: done_o 5 cycles after start; result_o=243, overflow_o=0.
//  2. base=2, exp=31: result_o=0x80000000, overflow_o=0.
//     base=2, exp=32: result_o=0, overflow_o=1.
//  3. base=0, exp=0: result_o=1, done at cycle 2.
//     base=0xFFFFFFFF, exp=2: result_o=1, overflow_o=1.
//  4. base=0x10000, exp=1: result_o=0x10000, overflow_o=0. The squaring overflow is never used.
//  5. Start 3^5, pulse start_i with 7^2 in cycle 2: ignored; result 243.
//     Next start 7^2 after done: result 49.
//  6. Start 2^20, assert ARESETN=0 at cycle 3: all outputs 0 immediately, no done_o.
//     After release, 5^3 yields 125.

Source files
------------

// File: rtl/exponent_core.sv
// Iterative integer power unit: result = base^exp mod 2^DATA_W by square-and-multiply,
// consuming one exponent bit per clock, with a sticky flag for a truncated true result.
module exponent_core #(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 32
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic              start_i,
  input  logic [DATA_W-1:0] base_i,
  input  logic [EXP_W-1:0]  exp_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o,
  output logic              overflow_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_r;
  logic [DATA_W-1:0]   acc_r;
  logic [DATA_W-1:0]   b_r;
  logic [EXP_W-1:0]    e_r;
  logic                b_ovf_r;
  logic                busy_r;
  logic                done_r;
  logic [DATA_W-1:0]   result_r;
  logic                ovf_r;

  logic [2*DATA_W-1:0] acc_prod_s;
  logic [2*DATA_W-1:0] sq_prod_s;
  logic                acc_hi_nz_s;
  logic                sq_hi_nz_s;

  // Two full-width multipliers working in parallel: accumulator update and base squaring.
  always_comb begin
    acc_prod_s  = {{DATA_W{1'b0}}, acc_r} * {{DATA_W{1'b0}}, b_r};
    sq_prod_s   = {{DATA_W{1'b0}}, b_r} * {{DATA_W{1'b0}}, b_r};
    acc_hi_nz_s = |acc_prod_s[2*DATA_W-1:DATA_W];
    sq_hi_nz_s  = |sq_prod_s[2*DATA_W-1:DATA_W];
  end

  // Control FSM and datapath; result/done are loaded on the RUN->DONE edge so they coincide.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_r  <= ST_IDLE;
      acc_r    <= {DATA_W{1'b0}};
      b_r      <= {DATA_W{1'b0}};
      e_r      <= {EXP_W{1'b0}};
      b_ovf_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {DATA_W{1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start_i) begin
            b_r     <= base_i;
            e_r     <= exp_i;
            acc_r   <= {{(DATA_W-1){1'b0}}, 1'b1};
            b_ovf_r <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (e_r == {EXP_W{1'b0}}) begin
            result_r <= acc_r;
            done_r   <= 1'b1;
            state_r  <= ST_DONE;
          end else begin
            // A saturated squared base only matters once it is multiplied into acc.
            if (e_r[0]) begin
              acc_r <= acc_prod_s[DATA_W-1:0];
              ovf_r <= ovf_r | acc_hi_nz_s | b_ovf_r;
            end else begin
              acc_r <= acc_r;
              ovf_r <= ovf_r;
            end
            b_r     <= sq_prod_s[DATA_W-1:0];
            b_ovf_r <= b_ovf_r | sq_hi_nz_s;
            e_r     <= {1'b0, e_r[EXP_W-1:1]};
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o     = busy_r;
  assign done_o     = done_r;
  assign result_o   = result_r;
  assign overflow_o = ovf_r;

endmodule

// File: tb/tb_exponent_core.sv
// Self-checking bench for exponent_core: directed vector table, hand-written
// start-ignore/reset sequences, and randomized operands against a math model.
module tb_exponent_core;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] base;
  logic [31:0] expo;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  exponent_core #(.DATA_W(32), .EXP_W(32)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .start_i      (start),
    .base_i       (base),
    .exp_i        (expo),
    .busy_o       (busy),
    .done_o       (done),
    .result_o     (result),
    .overflow_o   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] b;
    logic [31:0] e;
    logic [31:0] res;
    logic        ovf;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: exact math. Result mod 2^32 via binary powering in 64-bit arithmetic.
  function automatic logic [31:0] ref_pow(input logic [31:0] b, input logic [31:0] e);
    longint unsigned r = 64'd1;
    longint unsigned x = {32'd0, b};
    longint unsigned n = {32'd0, e};
    while (n != 64'd0) begin
      if (n[0]) r = (r * x) & 64'hFFFF_FFFF;
      x = (x * x) & 64'hFFFF_FFFF;
      n = n >> 1;
    end
    return r[31:0];
  endfunction

  // Reference: true b^e exceeds 32 bits (repeated multiply, stops once it overflows).
  function automatic logic ref_ovf(input logic [31:0] b, input logic [31:0] e);
    longint unsigned v = 64'd1;
    if (b < 32'd2) return 1'b0;
    for (longint unsigned i = 64'd0; i < {32'd0, e}; i++) begin
      v = v * {32'd0, b};
      if (v > 64'h0000_0000_FFFF_FFFF) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int ref_lat(input logic [31:0] e);
    int bl = 0;
    logic [31:0] t = e;
    while (t != 32'd0) begin
      bl++;
      t = t >> 1;
    end
    return bl + 2;
  endfunction

  // Present start for one edge, then scramble operands; returns cycle index of the accept.
  task automatic do_start(input logic [31:0] b, input logic [31:0] e, output int s);
    @(negedge clk);
    start = 1'b1;
    base  = b;
    expo  = e;
    @(posedge clk);
    #1;
    s     = cyc;
    start = 1'b0;
    base  = $urandom;
    expo  = $urandom;
  endtask

  task automatic wait_done(input int s, output logic [31:0] res, output logic ovf,
                           output int lat, output logic ok);
    ok  = 1'b0;
    lat = 0;
    res = 32'd0;
    ovf = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done) begin
        ok  = 1'b1;
        lat = cyc - s + 1;
        res = result;
        ovf = overflow;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done_o, expected done_o within 50 cycles");
    end else begin
      check("busy_at_done", {63'd0, busy}, 64'd1);
      @(negedge clk);
      check("done_pulse_one", {63'd0, done}, 64'd0);
      check("busy_after_done", {63'd0, busy}, 64'd0);
      check("result_held", {32'd0, result}, {32'd0, res});
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int s, lat;
    logic [31:0] res;
    logic ovf, ok;
    do_start(v.b, v.e, s);
    wait_done(s, res, ovf, lat, ok);
    if (ok) begin
      check({tag, "_result"}, {32'd0, res}, {32'd0, v.res});
      check({tag, "_ovf"}, {63'd0, ovf}, {63'd0, v.ovf});
      check({tag, "_latency"}, 64'(lat), 64'(v.lat));
    end
  endtask

  initial begin
    vec_t vt[13];
    vec_t rv;
    int s, lat;
    logic [31:0] res;
    logic ovf, ok;

    vt[0]  = '{32'd3,          32'd5,          32'd243,        1'b0, 5};
    vt[1]  = '{32'd2,          32'd31,         32'h8000_0000,  1'b0, 7};
    vt[2]  = '{32'd2,          32'd32,         32'd0,          1'b1, 8};
    vt[3]  = '{32'd0,          32'd0,          32'd1,          1'b0, 2};
    vt[4]  = '{32'hFFFF_FFFF,  32'd2,          32'd1,          1'b1, 4};
    vt[5]  = '{32'h0001_0000,  32'd1,          32'h0001_0000,  1'b0, 3};
    vt[6]  = '{32'd0,          32'd7,          32'd0,          1'b0, 5};
    vt[7]  = '{32'd1,          32'hFFFF_FFFF,  32'd1,          1'b0, 34};
    vt[8]  = '{32'h0001_2345,  32'd1,          32'h0001_2345,  1'b0, 3};
    vt[9]  = '{32'h0001_0000,  32'd2,          32'd0,          1'b1, 4};
    vt[10] = '{32'h0000_FFFF,  32'd2,          32'hFFFE_0001,  1'b0, 4};
    vt[11] = '{32'd3,          32'd20,         32'hCFD4_1B91,  1'b0, 7};
    vt[12] = '{32'd7,          32'd0,          32'd1,          1'b0, 2};

    rst_n = 1'b0;
    start = 1'b0;
    base  = 32'd0;
    expo  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_result", {32'd0, result}, 64'd0);
    check("reset_ovf", {63'd0, overflow}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_vec($sformatf("vec%0d", i), vt[i]);

    // start_i during RUN must be ignored, then accepted once back in IDLE.
    do_start(32'd3, 32'd5, s);
    @(posedge clk);
    #1;
    start = 1'b1;
    base  = 32'd7;
    expo  = 32'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_in_run", {63'd0, busy}, 64'd1);
    wait_done(s, res, ovf, lat, ok);
    if (ok) begin
      check("ignore_result", {32'd0, res}, 64'd243);
      check("ignore_latency", 64'(lat), 64'd5);
    end
    run_vec("b2b", '{32'd7, 32'd2, 32'd49, 1'b0, 4});

    // Asynchronous reset mid-RUN aborts with no done pulse and clears outputs.
    do_start(32'd2, 32'd20, s);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_result", {32'd0, result}, 64'd0);
    check("abort_ovf", {63'd0, overflow}, 64'd0);
    ok = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    check("abort_no_done", {63'd0, ok}, 64'd0);
    run_vec("after_rst", '{32'd5, 32'd3, 32'd125, 1'b0, 4});

    // Randomized operands against the math model.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       rv.b = $urandom_range(0, 20);
        1:       rv.b = $urandom;
        default: rv.b = $urandom_range(0, 32'h0001_FFFF);
      endcase
      case ($urandom_range(0, 2))
        0:       rv.e = $urandom_range(0, 40);
        1:       rv.e = $urandom;
        default: rv.e = $urandom_range(0, 3);
      endcase
      rv.res = ref_pow(rv.b, rv.e);
      rv.ovf = ref_ovf(rv.b, rv.e);
      rv.lat = ref_lat(rv.e);
      run_vec($sformatf("rand%0d_%0h^%0h", i, rv.b, rv.e), rv);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
